// File: rtl/irq_controller.sv
// Edge-collecting interrupt controller with masked fixed-priority arbitration and a small register window.
// Define IRQ_CTRL_ROUND_ROBIN_EN to rotate priority from the last serviced source.
module irq_controller #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src_irq,
  input  logic             kernel_mode,
  input  logic             irq_ack,
  input  logic             irq_done,
  input  logic [1:0]       bus_addr,
  input  logic             bus_wr,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  output logic             irq,
  output logic [ID_W-1:0]  irq_id
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t            state, state_next;
  logic              gie;
  logic [N_SRC-1:0]  mask, pending, src_prev;
  logic [N_SRC-1:0]  rise, eligible, id_sel, w1c_clear, ack_clear;
  logic [ID_W-1:0]   winner, irq_id_next;
  logic              any_eligible, cur_eligible, irq_next;
  logic              unused_wdata;

  assign rise         = src_irq & ~src_prev;
  assign eligible     = gie ? (pending & mask) : '0;
  assign any_eligible = |eligible;
  assign w1c_clear    = (bus_wr && bus_addr == 2'd2) ? bus_wdata[N_SRC-1:0] : '0;
  assign unused_wdata = ^bus_wdata;

  // One-hot of the latched id, so the live eligibility of the pending request can be watched.
  always_comb begin
    id_sel = '0;
    for (int unsigned i = 0; i < N_SRC; i++)
      id_sel[i] = (irq_id == ID_W'(i));
  end
  assign cur_eligible = |(eligible & id_sel);

`ifdef IRQ_CTRL_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_ptr;
  logic            found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < N_SRC; k++)
      for (int unsigned j = 0; j < N_SRC; j++)
        if (!found && eligible[j] && ((32'(rr_ptr) + k) % N_SRC) == j) begin
          winner = ID_W'(j);
          found  = 1'b1;
        end
  end

  always_ff @(posedge clk) begin
    if (reset)
      rr_ptr <= '0;
    else if (state == REQ && irq_ack)
      rr_ptr <= (irq_id == ID_W'(N_SRC - 1)) ? '0 : irq_id + 1'b1;
  end
`else
  // Scan downward so the lowest eligible index is the last one written.
  always_comb begin
    winner = '0;
    for (int unsigned i = N_SRC; i > 0; i--)
      if (eligible[i-1]) winner = ID_W'(i - 1);
  end
`endif

  always_comb begin
    state_next  = state;
    irq_next    = irq;
    irq_id_next = irq_id;
    ack_clear   = '0;
    case (state)
      IDLE: begin
        irq_next = 1'b0;
        if (any_eligible && !kernel_mode) begin
          state_next  = REQ;
          irq_next    = 1'b1;
          irq_id_next = winner;
        end
      end
      REQ: begin
        if (irq_ack) begin
          ack_clear  = id_sel;
          irq_next   = 1'b0;
          state_next = SERVICE;
        end else if (!cur_eligible) begin
          irq_next   = 1'b0;
          state_next = IDLE;
        end
      end
      SERVICE: begin
        irq_next = 1'b0;
        if (irq_done) state_next = IDLE;
      end
      default: begin
        irq_next   = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gie      <= 1'b0;
      mask     <= '0;
      pending  <= '0;
      src_prev <= '0;
      state    <= IDLE;
      irq      <= 1'b0;
      irq_id   <= '0;
    end else begin
      src_prev <= src_irq;
      pending  <= (pending & ~w1c_clear & ~ack_clear) | rise;
      if (bus_wr) begin
        case (bus_addr)
          2'd0:    gie  <= bus_wdata[0];
          2'd1:    mask <= bus_wdata[N_SRC-1:0];
          default: ;
        endcase
      end
      state  <= state_next;
      irq    <= irq_next;
      irq_id <= irq_id_next;
    end
  end

  always_comb begin
    bus_rdata = '0;
    case (bus_addr)
      2'd0: bus_rdata[0] = gie;
      2'd1: bus_rdata[N_SRC-1:0] = mask;
      2'd2: bus_rdata[N_SRC-1:0] = pending;
      2'd3: begin
        bus_rdata[ID_W-1:0] = irq_id;
        bus_rdata[31]       = (state == SERVICE);
      end
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed test-plan steps followed by random traffic, all checked cycle by cycle against a behavioural model.
module tb_irq_controller;

  localparam int N   = 4;
  localparam int IDW = 5;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   src_irq;
  logic           kernel_mode, irq_ack, irq_done, bus_wr;
  logic [1:0]     bus_addr;
  logic [31:0]    bus_wdata, bus_rdata;
  logic           irq;
  logic [IDW-1:0] irq_id;

  irq_controller #(.N_SRC(N), .ID_W(IDW)) dut (
    .clk(clk), .reset(reset), .src_irq(src_irq), .kernel_mode(kernel_mode),
    .irq_ack(irq_ack), .irq_done(irq_done), .bus_addr(bus_addr), .bus_wr(bus_wr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .irq(irq), .irq_id(irq_id)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference state: pending/mask as bit arrays, request and in-service as flags.
  bit m_pend [N];
  bit m_mask [N];
  bit m_prev [N];
  bit m_gie, m_irq, m_busy;
  int m_id, m_ptr;

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    logic [31:0] d;
    d = '0;
    case (a)
      2'd0: d[0] = m_gie;
      2'd1: for (int i = 0; i < N; i++) d[i] = m_mask[i];
      2'd2: for (int i = 0; i < N; i++) d[i] = m_pend[i];
      2'd3: begin d = 32'(m_id); d[31] = m_busy; end
    endcase
    return d;
  endfunction

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int idx = (m_ptr + k) % N;
      if (m_gie && m_pend[idx] && m_mask[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_update();
    bit n_pend [N];
    bit n_irq, n_busy;
    int n_id, w;
    if (reset) begin
      for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_mask[i] = 0; m_prev[i] = 0; end
      m_gie = 0; m_irq = 0; m_busy = 0; m_id = 0; m_ptr = 0;
      return;
    end
    n_irq = m_irq; n_busy = m_busy; n_id = m_id; n_pend = m_pend;
    if (!m_irq && !m_busy) begin
      w = pick();
      if (w >= 0 && !kernel_mode) begin n_irq = 1; n_id = w; end
    end else if (m_irq) begin
      if (irq_ack) begin
        n_irq = 0; n_busy = 1; n_pend[m_id] = 0;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
        m_ptr = (m_id + 1) % N;
`endif
      end else if (!(m_gie && m_pend[m_id] && m_mask[m_id])) begin
        n_irq = 0;
      end
    end else if (irq_done) begin
      n_busy = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (bus_wr && bus_addr == 2'd2 && bus_wdata[i]) n_pend[i] = 0;
      if (src_irq[i] && !m_prev[i]) n_pend[i] = 1;
      m_prev[i] = src_irq[i];
    end
    if (bus_wr && bus_addr == 2'd0) m_gie = bus_wdata[0];
    if (bus_wr && bus_addr == 2'd1)
      for (int i = 0; i < N; i++) m_mask[i] = bus_wdata[i];
    m_pend = n_pend; m_irq = n_irq; m_busy = n_busy; m_id = n_id;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    irq_ack = 1'b0; irq_done = 1'b0; bus_wr = 1'b0;
    check("irq", 32'(irq), 32'(m_irq));
    check("irq_id", 32'(irq_id), 32'(m_id));
    for (int a = 0; a < 4; a++) begin
      bus_addr = 2'(a);
      #1;
      check($sformatf("rd%0d", a), bus_rdata, model_rd(2'(a)));
    end
  endtask

  task automatic rdchk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    bus_addr = a;
    #1;
    check(tag, bus_rdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus_addr = a; bus_wdata = d; bus_wr = 1'b1;
    step();
  endtask

  initial begin
    int first_id, second_id;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
    first_id = 3; second_id = 1;
`else
    first_id = 1; second_id = 3;
`endif
    reset = 1'b1; src_irq = '0; kernel_mode = 1'b0; irq_ack = 1'b0; irq_done = 1'b0;
    bus_wr = 1'b0; bus_addr = '0; bus_wdata = '0;
    step(); step();
    reset = 1'b0;
    check("rst_irq", 32'(irq), 32'd0);
    rdchk("rst_ctrl", 2'd0, 32'd0);
    rdchk("rst_mask", 2'd1, 32'd0);
    rdchk("rst_pend", 2'd2, 32'd0);

    wr(2'd0, 32'h1);
    wr(2'd1, 32'hFFFF_FFFF);
    rdchk("mask_hi_ignored", 2'd1, 32'hF);
    repeat (4) step();

    // single source: pending, request, ack, done
    src_irq = 4'b0100; step();
    check("s1_irq_pend_cycle", 32'(irq), 32'd0);
    rdchk("s1_pend", 2'd2, 32'h4);
    src_irq = '0; step();
    check("s1_irq", 32'(irq), 32'd1);
    rdchk("s1_cause_req", 2'd3, 32'h2);
    irq_ack = 1'b1; step();
    check("s1_irq_after_ack", 32'(irq), 32'd0);
    rdchk("s1_pend_ack", 2'd2, 32'h0);
    rdchk("s1_cause_svc", 2'd3, 32'h8000_0002);
    irq_done = 1'b1; step();
    rdchk("s1_cause_done", 2'd3, 32'h2);

    // simultaneous edges on 1 and 3
    src_irq = 4'b1010; step();
    src_irq = '0; step();
    check("s2_first_irq", 32'(irq), 32'd1);
    check("s2_first_id", 32'(irq_id), 32'(first_id));
    irq_ack = 1'b1; step();
    irq_done = 1'b1; step();
    step();
    check("s2_second_irq", 32'(irq), 32'd1);
    check("s2_second_id", 32'(irq_id), 32'(second_id));
    irq_ack = 1'b1; step();
    irq_done = 1'b1; step();
    step();

    // kernel mode blocks requests
    kernel_mode = 1'b1; src_irq = 4'b0001; step();
    src_irq = '0; step(); step();
    check("s3_kernel_blocks", 32'(irq), 32'd0);
    kernel_mode = 1'b0; step(); step();
    check("s3_irq_after_kernel", 32'(irq), 32'd1);
    check("s3_id", 32'(irq_id), 32'd0);

    // masking the requested source withdraws the request
    wr(2'd1, 32'hE);
    step();
    check("s4_withdrawn", 32'(irq), 32'd0);
    rdchk("s4_pend_kept", 2'd2, 32'h1);
    wr(2'd1, 32'hF);
    step();
    check("s4_rerequest", 32'(irq), 32'd1);
    irq_ack = 1'b1; step();
    irq_done = 1'b1; step();

    // set beats write-1-to-clear on the same bit
    wr(2'd0, 32'h0);
    src_irq = 4'b0100; bus_addr = 2'd2; bus_wdata = 32'h4; bus_wr = 1'b1; step();
    rdchk("s5_set_wins", 2'd2, 32'h4);
    src_irq = '0;
    wr(2'd2, 32'hF);
    rdchk("s5_w1c", 2'd2, 32'h0);
    wr(2'd0, 32'h1);

    // reset while in service
    src_irq = 4'b0010; step();
    src_irq = '0; step();
    check("s6_req", 32'(irq), 32'd1);
    irq_ack = 1'b1; step();
    rdchk("s6_cause_svc", 2'd3, 32'h8000_0001);
    reset = 1'b1; step();
    reset = 1'b0;
    check("s6_rst_irq", 32'(irq), 32'd0);
    rdchk("s6_rst_cause", 2'd3, 32'h0);
    rdchk("s6_rst_pend", 2'd2, 32'h0);
    src_irq = 4'b1000; step();
    rdchk("s6_rst_ctrl", 2'd0, 32'h0);
    src_irq = '0; repeat (3) step();
    check("s6_gie_off", 32'(irq), 32'd0);

    // random traffic
    wr(2'd0, 32'h1);
    wr(2'd1, 32'hF);
    for (int n = 0; n < 800; n++) begin
      reset       = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 2) == 0) src_irq = N'($urandom);
      kernel_mode = ($urandom_range(0, 3) == 0);
      irq_ack     = ($urandom_range(0, 2) == 0);
      irq_done    = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) begin
        bus_wr    = 1'b1;
        bus_addr  = 2'($urandom);
        bus_wdata = $urandom;
      end
      step();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt controller for the single-cycle MIPS core.
- Collects up to N peripheral interrupt sources (timer, UART rx/tx, keys) as rising edges and holds them as pending.
- Applies a global enable and per-source masks, then picks one winner by priority.
- Drives the IRQ input of the control unit, where IRQ selects PCSrc=3'b100 and writes PC+4 to $k0. It blocks nesting until the handler signals completion. Software accesses it through a small memory-mapped register window.

Parameters:
- N_SRC, 4, number of interrupt sources (1..32).
- ID_W, 5, width of the cause ID field.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- src_irq  in  N_SRC  raw source lines, synchronous to clk; a rising edge sets pending.
- kernel_mode  in  1  PC[31] of the current instruction; 1 = in handler, never interrupt.
- irq_ack  in  1  core took the interrupt this cycle (control unit PCSrc==3'b100).
- irq_done  in  1  handler return (jr $k0 executed in kernel mode), one-cycle pulse.
- bus_addr  in  2  word select within the window (addr[3:2]).
- bus_wr  in  1  register write strobe.
- bus_wdata  in  32  write data.
- bus_rdata  out  32  read data, combinational from bus_addr.
- irq  out  1  interrupt request to the control unit, registered.
- irq_id  out  ID_W  index of the source being serviced, registered.

Behaviour:
- Register map:
  - 0 CTRL: bit0 GIE; other bits read as 0.
  - 1 MASK: bits[N_SRC-1:0], 1 = enabled.
  - 2 PEND: write-1-to-clear; read returns pending.
  - 3 CAUSE: read-only; [ID_W-1:0] = irq_id, bit31 = in_service.
- Reset: GIE=0, MASK=0, PEND=0, src_prev=0, state=IDLE, irq=0, irq_id=0, bus_rdata follows the reset register values.
- Edge detect: src_prev <= src_irq each cycle; rise = src_irq & ~src_prev.
- pending <= (pending & ~w1c_clear & ~ack_clear) | rise. If a set and a clear hit the same bit in the same cycle, the set wins.
- eligible = pending & MASK, gated by GIE.
- Fixed priority: the lowest index wins.
- State machine:
  - IDLE: if |eligible and !kernel_mode, latch irq_id = winner, set irq=1 on the next edge, go to REQ.
  - REQ: irq held at 1 until irq_ack. On irq_ack: clear pending[irq_id], irq=0 on the next edge, go to SERVICE.
  - If eligible[irq_id] drops (software masked or cleared it) before the ack: irq=0, go to IDLE. The request is withdrawn with no ack.
  - SERVICE: irq=0. On irq_done go to IDLE. New edges keep accumulating in pending.
  - IDLE re-evaluates in the cycle after leaving SERVICE, so back-to-back service needs at least 1 idle cycle.
- Latency: a source edge at cycle t gives pending at t+1 and irq=1 at t+2 at the earliest.
- irq_id is stable from REQ entry until the next IDLE→REQ transition.
- irq_ack outside REQ and irq_done outside SERVICE are ignored.
- Bus writes take effect on the next edge. Reads of PEND in the same cycle as a write return the pre-write value.
- Bits of MASK and PEND at N_SRC and above read as 0 and ignore writes.
- A reset asserted mid-REQ or mid-SERVICE returns to IDLE with irq=0 in the following cycle.

Optional Feature:
- Macro: IRQ_CTRL_ROUND_ROBIN_EN.
- Defined: rotating priority. The search starts at (last serviced id + 1) mod N_SRC; the pointer updates on irq_ack and resets to 0.
- Undefined: fixed priority, lowest index wins, no pointer register.

Test Plan:
- Reset, then GIE=1, MASK=4'b1111, pulse src_irq[2] at cycle 10 → irq=1 at cycle 12, CAUSE=0x00000002; ack → PEND bit2=0, CAUSE=0x80000002; irq_done → CAUSE bit31=0.
- src_irq[3] and src_irq[1] rise in the same cycle → irq_id=1 first. After done plus 1 idle cycle, irq_id=3. With ROUND_ROBIN_EN and last id=1, irq_id=3 first.
- kernel_mode=1 while pending[0]=1 and enabled → irq stays 0; kernel_mode drops to 0 → irq=1 two cycles later.
- In REQ with irq_id=0, write MASK=4'b1110 before the ack → irq=0 next cycle, state IDLE, no pending bit cleared.
- Write PEND=4'b0100 in the same cycle src_irq[2] rises → PEND bit2 reads 1 afterwards (set wins).
- Assert reset during SERVICE → next cycle irq=0, CAUSE=0, PEND=0, GIE=0; a subsequent src edge with GIE=0 → irq stays 0.
